// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
//   Shared TPU definitions: float bias constants, float15/float8 field slices,
//   the result-collector state encoding and a float8 ordering helper.
// ----------------------------------------------------------------------------
package tpu_pkg;

  localparam int         FLOAT15_BIAS   = 31;
  localparam int         FLOAT8_BIAS    = 7;
  localparam logic [7:0] FLOAT8_MAX_POS = 8'h7F;

  // float15 = {s[14], e[13:8], m[7:0]}
  localparam int F15_SIGN   = 14;
  localparam int F15_EXP_HI = 13;
  localparam int F15_EXP_LO = 8;
  localparam int F15_MAN_HI = 7;

  // Largest biased exponent representable in the 4-bit float8 exponent field.
  localparam int F8_EXP_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_e;

  // Strict "a > b" for sign-magnitude float8. Exponent and mantissa are
  // contiguous, so the low 7 bits order magnitudes directly; the sign turns
  // them into a signed key (negative < zero < positive).
  function automatic logic f8_gt(input logic [7:0] a, input logic [7:0] b);
    int ka;
    int kb;
    ka = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    kb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    return ka > kb;
  endfunction

endpackage

// File: rtl/tpu_result_collector_if.sv
// ----------------------------------------------------------------------------
// tpu_result_collector_if
//   Control, result-stream and layer-output signals of the result collector.
//   master: the side that starts layers and feeds MAC results.
//   slave : the collector itself.
// ----------------------------------------------------------------------------
interface tpu_result_collector_if #(
  parameter int N_OUT = 128,
  parameter int IDX_W = 7
);
  logic               start;
  logic [7:0]         len;
  logic               relu_en;
  logic               in_valid;
  logic               in_ready;
  logic [14:0]        in_sum;
  logic               in_ovf;
  logic [N_OUT*8-1:0] out_vec;
  logic               out_valid;
  logic [IDX_W-1:0]   argmax;
  logic [7:0]         max_val;
  logic [7:0]         sat_cnt;
  logic               busy;

  modport master (
    output start, len, relu_en, in_valid, in_sum, in_ovf,
    input  in_ready, out_vec, out_valid, argmax, max_val, sat_cnt, busy
  );

  modport slave (
    input  start, len, relu_en, in_valid, in_sum, in_ovf,
    output in_ready, out_vec, out_valid, argmax, max_val, sat_cnt, busy
  );
endinterface

// File: rtl/float15_to_float8.sv
// ----------------------------------------------------------------------------
// float15_to_float8
//   Combinational requantiser, float15 {s,e6,m8} bias 31 -> float8 {s,e4,m3}
//   bias 7, truncating the mantissa. Optional ReLU clamps negatives to zero.
//   Ports: in_sum (float15), in_ovf (MAC overflow), relu_en,
//          f8 (float8 result), sat (result was saturated).
// ----------------------------------------------------------------------------
module float15_to_float8
  import tpu_pkg::*;
(
  input  logic [14:0] in_sum,
  input  logic        in_ovf,
  input  logic        relu_en,
  output logic [7:0]  f8,
  output logic        sat
);

  logic              sign;
  logic [5:0]        e15;
  logic [2:0]        man;
  logic signed [7:0] e8;

  assign sign = in_sum[F15_SIGN];
  assign e15  = in_sum[F15_EXP_HI:F15_EXP_LO];
  assign man  = in_sum[F15_MAN_HI -: 3];
  // Signed rebias: float15 exponents span -24..39 once moved to float8 bias.
  assign e8   = $signed({2'b00, e15}) - 8'(FLOAT15_BIAS - FLOAT8_BIAS);

  // NOTE: every output gets a default before the decision chain, so no path
  // leaves f8/sat unassigned and no latch is inferred.
  always_comb begin
    f8  = 8'h00;
    sat = 1'b0;
    if (in_ovf) begin
      sat = 1'b1;
      f8  = (relu_en && sign) ? 8'h00 : {sign, FLOAT8_MAX_POS[6:0]};
    end else if (relu_en && sign) begin
      f8 = 8'h00;
    end else if (in_sum[13:0] == 14'd0) begin
      f8 = 8'h00;                          // signed zero collapses to +0
    end else if (e8 > 8'(F8_EXP_MAX)) begin
      sat = 1'b1;
      f8  = {sign, FLOAT8_MAX_POS[6:0]};
    end else if (e8 < 8'sd1) begin
      f8 = 8'h00;                          // below float8 range: flush
    end else begin
      f8 = {sign, e8[3:0], man};
    end
  end

endmodule

// File: rtl/tpu_result_collector.sv
// ----------------------------------------------------------------------------
// tpu_result_collector
//   Collects one MAC dot-product sum per neuron, requantises it to float8
//   (optional ReLU), packs it into an N_OUT x 8 activation vector and tracks
//   argmax / max value across the layer.
//   Ports: clk, rst (async, active high), bus (slave modport):
//     start/len/relu_en  layer control, len and relu_en sampled on start
//     in_valid/in_ready/in_sum/in_ovf  result stream
//     out_vec/out_valid/argmax/max_val/sat_cnt/busy  layer outputs
// ----------------------------------------------------------------------------
module tpu_result_collector
  import tpu_pkg::*;
#(
  parameter int N_OUT = 128,
  parameter int IDX_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  tpu_result_collector_if.slave  bus
);

  localparam logic [7:0] N_OUT_L = 8'(N_OUT);

  collector_state_e   state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         len_q, len_d;
  logic               relu_q, relu_d;
  logic [N_OUT*8-1:0] vec_q, vec_d;
  logic [IDX_W-1:0]   argmax_q, argmax_d;
  logic [7:0]         max_q, max_d;
  logic [7:0]         sat_q, sat_d;

  logic               in_ready;
  logic               hs;
  logic [7:0]         eff_len;
  logic [N_OUT-1:0]   slot_sel;
  logic [7:0]         f8;
  logic               f8_sat;

  float15_to_float8 u_requant (
    .in_sum  (bus.in_sum),
    .in_ovf  (bus.in_ovf),
    .relu_en (relu_q),
    .f8      (f8),
    .sat     (f8_sat)
  );

  // A start pulse wins over any result presented in the same cycle.
  assign in_ready = (state_q == ST_COLLECT) && !bus.start;
  assign hs       = bus.in_valid && in_ready;
  // len of 0 selects a full layer; oversize lengths are clamped to N_OUT.
  assign eff_len  = (bus.len == 8'd0 || bus.len > N_OUT_L) ? N_OUT_L : bus.len;
  assign slot_sel = N_OUT'(1) << count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    relu_d   = relu_q;
    vec_d    = vec_q;
    argmax_d = argmax_q;
    max_d    = max_q;
    sat_d    = sat_q;

    if (bus.start) begin
      state_d  = ST_COLLECT;
      count_d  = 8'd0;
      len_d    = eff_len;
      relu_d   = bus.relu_en;
      vec_d    = '0;
      argmax_d = '0;
      max_d    = 8'h00;
      sat_d    = 8'h00;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (hs) begin
            for (int k = 0; k < N_OUT; k++) begin
              if (slot_sel[k]) vec_d[8*k +: 8] = f8;
            end
            if (f8_sat && sat_q != 8'hFF) sat_d = sat_q + 8'd1;
            // First result always loads; later ones only if strictly greater.
            if (count_q == 8'd0 || f8_gt(f8, max_q)) begin
              argmax_d = count_q[IDX_W-1:0];
              max_d    = f8;
            end
            count_d = count_q + 8'd1;
            if (count_q + 8'd1 == len_q) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: the activation vector is a flop bank rather than a RAM, so it takes
  // the async reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 8'd0;
      len_q    <= 8'd0;
      relu_q   <= 1'b0;
      vec_q    <= '0;
      argmax_q <= '0;
      max_q    <= 8'h00;
      sat_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      relu_q   <= relu_d;
      vec_q    <= vec_d;
      argmax_q <= argmax_d;
      max_q    <= max_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_vec   = vec_q;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.argmax    = argmax_q;
  assign bus.max_val   = max_q;
  assign bus.sat_cnt   = sat_q;
  assign bus.busy      = (state_q == ST_COLLECT);

endmodule
